instr_fetch_unit: RTL

//  Instruction fetch stage of the 16-bit TSC pipeline. Owns the PC and issues read requests to

---
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage of the 16-bit TSC pipeline.
//
// The unit owns the PC and issues read requests to instruction memory using the
// i_readM/inputReady handshake. It keeps the fetched word in the IF/ID register.
// It handles decode stalls, flushes and branch/jump redirects, and no instruction
// is lost or duplicated along the way.
//
// Ports:
//   clk, reset_n      clock (posedge) and asynchronous active-low reset
//   i_readM           instruction memory read request (FETCH state, out of reset)
//   i_address         fetch address (= pc)
//   i_data            instruction word, valid when inputReady=1
//   inputReady        memory returns i_data this cycle
//   stall             decode cannot accept, so IF/ID is held
//   flush             invalidate IF/ID
//   redirect_valid    load redirect_target into pc (taken branch/jump)
//   redirect_target   new pc value
//   if_id_valid       IF/ID holds a real instruction
//   if_id_instr       instruction to the control unit
//   if_id_pc          address of if_id_instr
//   if_id_pc_next     if_id_pc + 1 (link value), combinational
//   fetch_count       (only with FETCH_COUNT_EN) number of instructions accepted into IF/ID
//
// Optional feature: define FETCH_COUNT_EN to add the fetch_count output and its counter.

module instr_fetch_unit #(
  parameter int unsigned          WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 inputReady,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_target,
  output logic                 if_id_valid,
  output logic [WORD_SIZE-1:0] if_id_instr,
  output logic [WORD_SIZE-1:0] if_id_pc,
  output logic [WORD_SIZE-1:0] if_id_pc_next
`ifdef FETCH_COUNT_EN
  ,
  output logic [WORD_SIZE-1:0] fetch_count
`endif
);

  typedef enum logic [0:0] {StFetch, StHold} state_e;

  state_e               state_q;
  logic [WORD_SIZE-1:0] pc_q;
  logic [WORD_SIZE-1:0] buf_q;
  logic [WORD_SIZE-1:0] buf_pc_q;
  logic                 valid_q;
  logic [WORD_SIZE-1:0] instr_q;
  logic [WORD_SIZE-1:0] id_pc_q;
`ifdef FETCH_COUNT_EN
  logic [WORD_SIZE-1:0] count_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      buf_q    <= '0;
      buf_pc_q <= '0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      id_pc_q  <= '0;
`ifdef FETCH_COUNT_EN
      count_q  <= '0;
`endif
    end else if (redirect_valid) begin
      // A word returning in this cycle belongs to the wrong path and is dropped.
      // Any parked word is discarded the same way.
      pc_q    <= redirect_target;
      valid_q <= 1'b0;
      state_q <= StFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (inputReady) begin
            pc_q <= pc_q + 1'b1;
            if (stall) begin
              // Decode is busy. Park the word and stop requesting until the stall clears.
              buf_q    <= i_data;
              buf_pc_q <= pc_q;
              state_q  <= StHold;
            end else begin
              instr_q <= i_data;
              id_pc_q <= pc_q;
              valid_q <= 1'b1;
`ifdef FETCH_COUNT_EN
              if (!flush) count_q <= count_q + 1'b1;
`endif
            end
          end else if (!stall) begin
            valid_q <= 1'b0;
          end
        end
        StHold: begin
          if (!stall) begin
            instr_q <= buf_q;
            id_pc_q <= buf_pc_q;
            valid_q <= 1'b1;
            state_q <= StFetch;
`ifdef FETCH_COUNT_EN
            if (!flush) count_q <= count_q + 1'b1;
`endif
          end
        end
        default: state_q <= StFetch;
      endcase
      // flush overrides any load above and always forces a bubble.
      if (flush) valid_q <= 1'b0;
    end
  end

  // The request drops during reset even though the state already reads FETCH.
  assign i_readM       = reset_n && (state_q == StFetch);
  assign i_address     = pc_q;
  assign if_id_valid   = valid_q;
  assign if_id_instr   = instr_q;
  assign if_id_pc      = id_pc_q;
  assign if_id_pc_next = id_pc_q + 1'b1;
`ifdef FETCH_COUNT_EN
  assign fetch_count   = count_q;
`endif

endmodule
